alu_reg_ctrl: RTL and testbench
===============================

// Module: alu_reg_ctrl
// PURPOSE
//  Instruction sequencer that drives reg_file + alu (replaces bench stimulus).
//  Accepts one instruction per valid/ready handshake, reads rs1/rs2, runs the ALU op,
//  writes result back to rd, and returns result + zero flag on a done handshake.
//  Sits between an instruction source and the reg_file/alu datapath pair.
// PARAMETERS
//  WIDTH  8  data width; matches reg_file d/q and alu a/b/result
//  AW     3  register address width (2**AW registers)
//  OPW    3  alu op code width
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      asynchronous, active-low reset (0 = reset)
//  instr_valid   in   1      instruction present
//  instr_ready   out  1      controller can accept instruction
//  instr_op      in   OPW    alu op (000 add .. 111 shr, alu encoding)
//  instr_imm_en  in   1      1 = load immediate to rd, no ALU op
//  instr_imm     in   WIDTH  immediate value
//  instr_rd      in   AW     destination register
//  instr_rs1     in   AW     source a
//  instr_rs2     in   AW     source b
//  rf_load       out  1      reg_file write enable
//  rf_d          out  WIDTH  reg_file write data
//  rf_sel_w      out  AW     reg_file write address
//  rf_sel_r1     out  AW     reg_file read address 1
//  rf_sel_r2     out  AW     reg_file read address 2
//  alu_op        out  OPW    alu operation select
//  alu_result    in   WIDTH  alu result (combinational from q1/q2)
//  alu_zero      in   1      alu zero flag
//  done_valid    out  1      completed result available
//  done_ready    in   1      consumer accepts result
//  done_result   out  WIDTH  value written to rd
//  done_zero     out  1      1 iff done_result == 0
//  busy          out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; every output 0 except instr_ready=1;
//    latched instruction, result and zero registers cleared. Reset during WB drops
//    rf_load immediately: no write occurs.
//  - FSM: IDLE -> EXEC -> WB -> RESP -> IDLE; imm path IDLE -> WB -> RESP -> IDLE.
//  - IDLE: instr_ready=1. On instr_valid&&instr_ready at an edge, latch all instr_*
//    fields; go to WB if instr_imm_en, else EXEC. Inputs outside the handshake are ignored.
//  - EXEC (1 cycle): rf_sel_r1/rf_sel_r2/alu_op driven from latched fields; at the edge
//    capture alu_result -> res_q and alu_zero -> zero_q; go to WB.
//  - WB (1 cycle): rf_load=1, rf_sel_w=rd, rf_d=res_q (imm path: res_q=imm,
//    zero_q=(imm==0) set on acceptance); go to RESP.
//  - RESP: done_valid=1, done_result=res_q, done_zero=zero_q, held stable until
//    done_valid&&done_ready at an edge, then IDLE. instr_ready=0 in all non-IDLE states.
//  - rf_load is high for exactly one cycle per instruction, never outside WB.
//  - rf_sel_*, alu_op hold the latched values outside their active state (no glitching to 0).
//  - Latency: ALU instr accepted edge N -> rf write at edge N+2 -> done_valid from
//    cycle N+2 (after edge N+2) ... i.e. EXEC cycle N+1, WB cycle N+2, RESP cycle N+3.
//    Imm path is one cycle shorter. Throughput: 1 instr / 4 cycles (3 for imm)
//    with done_ready held high.
//  - rd == rs1 or rs2 is legal: operands are read in EXEC before the WB write.
//  - Arithmetic wraps modulo 2**WIDTH (alu behaviour); controller never alters data.
// TESTING
//  - imm 0x0F->r0, imm 0x03->r1 -> two single-cycle rf_load pulses; done_result 0x0F, 0x03.
//  - ADD r2=r0+r1 (op 000) -> rf_d=0x12 at sel_w=2; done_result 0x12, done_zero 0.
//  - SUB r3=r1-r1 (op 001) -> done_result 0x00, done_zero 1; SHR r4=r0 (op 111) -> 0x07.
//  - done_ready low 3 cycles in RESP -> done_valid/result stable, instr_ready 0, no extra rf_load.
//  - ADD r0=r0+r1 (rd==rs1) -> r0 becomes 0x12 exactly once; readback via r0+imm0 r7 = 0x12.
//  - reset pulled low during WB -> rf_load 0 same cycle, all outputs reset, target reg unchanged.

Source files
------------

// File: rtl/alu_reg_ctrl.sv
// Instruction sequencer for a reg_file + alu datapath pair.
// Accepts one instruction per valid/ready handshake, reads operands, captures the
// ALU result, writes it back to rd, then presents result + zero flag until accepted.
// Immediate instructions skip the execute step and write the immediate directly.
module alu_reg_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 3,
   parameter int unsigned OPW   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [OPW-1:0]   instr_op,
   input  logic             instr_imm_en,
   input  logic [WIDTH-1:0] instr_imm,
   input  logic [AW-1:0]    instr_rd,
   input  logic [AW-1:0]    instr_rs1,
   input  logic [AW-1:0]    instr_rs2,
   output logic             rf_load,
   output logic [WIDTH-1:0] rf_d,
   output logic [AW-1:0]    rf_sel_w,
   output logic [AW-1:0]    rf_sel_r1,
   output logic [AW-1:0]    rf_sel_r2,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] done_result,
   output logic             done_zero,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StExec, StWb, StResp} state_e;

   state_e           state_q, state_d;
   logic [OPW-1:0]   op_q;
   logic [AW-1:0]    rd_q, rs1_q, rs2_q;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             accept;

   assign accept = (state_q == StIdle) && instr_valid;

   // Latch the instruction fields on acceptance; they hold until the next instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q  <= '0;
         rd_q  <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
      end else if (accept) begin
         op_q  <= instr_op;
         rd_q  <= instr_rd;
         rs1_q <= instr_rs1;
         rs2_q <= instr_rs2;
      end
   end

   // Result source: immediate at acceptance, ALU output at the end of EXEC.
   always_comb begin
      res_d  = res_q;
      zero_d = zero_q;
      if (accept && instr_imm_en) begin
         res_d  = instr_imm;
         zero_d = (instr_imm == '0);
      end else if (state_q == StExec) begin
         res_d  = alu_result;
         zero_d = alu_zero;
      end
   end

   // Result and zero-flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         res_q  <= res_d;
         zero_q <= zero_d;
      end
   end

   // State register; async reset drops out of WB at once so no write can occur.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake/datapath control outputs.
   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      rf_load     = 1'b0;
      done_valid  = 1'b0;
      busy        = 1'b1;
      unique case (state_q)
         StIdle: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
            if (instr_valid) begin
               state_d = instr_imm_en ? StWb : StExec;
            end
         end
         StExec: begin
            state_d = StWb;
         end
         StWb: begin
            rf_load = 1'b1;
            state_d = StResp;
         end
         StResp: begin
            done_valid = 1'b1;
            if (done_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Addresses and op hold the latched values in every state to avoid glitching.
   assign rf_sel_w    = rd_q;
   assign rf_sel_r1   = rs1_q;
   assign rf_sel_r2   = rs2_q;
   assign alu_op      = op_q;
   assign rf_d        = res_q;
   assign done_result = res_q;
   assign done_zero   = zero_q;

endmodule

// File: tb/tb_alu_reg_ctrl.sv
// Self-checking bench for alu_reg_ctrl with a behavioural reg_file + alu around it.
module tb_alu_reg_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid, instr_ready, instr_imm_en;
   logic [2:0] instr_op, instr_rd, instr_rs1, instr_rs2;
   logic [7:0] instr_imm;
   logic       rf_load;
   logic [7:0] rf_d;
   logic [2:0] rf_sel_w, rf_sel_r1, rf_sel_r2, alu_op;
   logic [7:0] alu_result;
   logic       alu_zero;
   logic       done_valid, done_ready, done_zero, busy;
   logic [7:0] done_result;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   alu_reg_ctrl #(.WIDTH(8), .AW(3), .OPW(3)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_imm_en(instr_imm_en), .instr_imm(instr_imm), .instr_rd(instr_rd),
      .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .rf_load(rf_load), .rf_d(rf_d), .rf_sel_w(rf_sel_w), .rf_sel_r1(rf_sel_r1),
      .rf_sel_r2(rf_sel_r2), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
      .done_valid(done_valid), .done_ready(done_ready), .done_result(done_result),
      .done_zero(done_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   // Generic ALU: add, sub, and, or, xor, not a, shl 1, shr 1; wraps mod 256.
   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ~a;
         3'd6: return a << 1;
         default: return a >> 1;
      endcase
   endfunction

   // Datapath environment: register file written on rf_load, combinational ALU.
   logic [7:0] env_rf [8] = '{default: 8'h00};
   always @(posedge clk) if (rf_load) env_rf[rf_sel_w] <= rf_d;
   always_comb begin
      alu_result = alu_f(alu_op, env_rf[rf_sel_r1], env_rf[rf_sel_r2]);
      alu_zero   = (alu_result == 8'h00);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural model: program-ordered register values and expected completions.
   typedef struct {
      logic       imm;
      logic [2:0] op, rd, rs1, rs2;
      logic [7:0] res;
      logic       zero;
   } exp_t;
   exp_t       q[$];
   logic [7:0] model_rf [8] = '{default: 8'h00};

   // Per-cycle comparison against the model's timeline for the in-flight instruction.
   exp_t cur;
   bit   track = 1'b0;
   int   age   = 0;
   always @(negedge clk) begin
      int wb_age;
      if (chk_en) begin
         if (track) age++;
         wb_age = cur.imm ? 1 : 2;
         chk("rf_load", rf_load, int'(track && age == wb_age));
         if (rf_load) begin
            chk("rf_sel_w", rf_sel_w, cur.rd);
            chk("rf_d", rf_d, cur.res);
         end
         if (track && !cur.imm && age == 1) begin
            chk("rf_sel_r1", rf_sel_r1, cur.rs1);
            chk("rf_sel_r2", rf_sel_r2, cur.rs2);
            chk("alu_op", alu_op, cur.op);
         end
         chk("done_valid", done_valid, int'(track && age > wb_age));
         if (done_valid) begin
            chk("done_result", done_result, cur.res);
            chk("done_zero", done_zero, cur.zero);
         end
         chk("instr_ready", instr_ready, int'(!track));
         chk("busy", busy, int'(track));
         if (done_valid && done_ready) track = 1'b0;
         if (instr_valid && instr_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_accept", 1, 0);
            end else begin
               cur   = q.pop_front();
               track = 1'b1;
               age   = 0;
            end
         end
      end
   end

   task automatic issue(input logic ie, input logic [7:0] imm, input logic [2:0] op,
                        input logic [2:0] rd, rs1, rs2);
      exp_t e;
      bit   ok = 1'b0;
      e.imm = ie; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      e.res  = ie ? imm : alu_f(op, model_rf[rs1], model_rf[rs2]);
      e.zero = (e.res == 8'h00);
      model_rf[rd] = e.res;
      q.push_back(e);
      instr_imm_en = ie; instr_imm = imm; instr_op = op;
      instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
      instr_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (instr_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      // Garbage on the fields outside the handshake must be ignored.
      instr_imm_en = ~ie; instr_imm = 8'hEE; instr_op = 3'd5;
      instr_rd = 3'd6; instr_rs1 = 3'd7; instr_rs2 = 3'd7;
   endtask

   task automatic wait_done(input logic [7:0] exp_res, input logic exp_zero);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_valid && done_ready) begin
            ok = 1'b1;
            chk("lit_result", done_result, exp_res);
            chk("lit_zero", done_zero, exp_zero);
            break;
         end
      end
      if (!ok) chk("done_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_instr_ready", instr_ready, 1);
      chk("rst_rf_load", rf_load, 0);
      chk("rst_rf_d", rf_d, 0);
      chk("rst_sels", {rf_sel_w, rf_sel_r1, rf_sel_r2, alu_op}, 0);
      chk("rst_done", {done_valid, done_result, done_zero}, 0);
      chk("rst_busy", busy, 0);
   endtask

   initial begin
      bit ok;
      reset = 1'b0; done_ready = 1'b1; instr_valid = 1'b0; instr_imm_en = 1'b0;
      instr_imm = '0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
      #3;
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      chk_en = 1'b1;

      issue(1'b1, 8'h0F, 3'd0, 3'd0, 3'd0, 3'd0); wait_done(8'h0F, 1'b0);
      issue(1'b1, 8'h03, 3'd0, 3'd1, 3'd0, 3'd0); wait_done(8'h03, 1'b0);
      issue(1'b0, 8'h00, 3'd0, 3'd2, 3'd0, 3'd1); wait_done(8'h12, 1'b0);
      chk("lit_r2", env_rf[2], 8'h12);
      issue(1'b0, 8'h00, 3'd1, 3'd3, 3'd1, 3'd1); wait_done(8'h00, 1'b1);
      issue(1'b0, 8'h00, 3'd7, 3'd4, 3'd0, 3'd0); wait_done(8'h07, 1'b0);

      // Consumer stall: result must hold, nothing new accepted or written.
      done_ready = 1'b0;
      issue(1'b0, 8'h00, 3'd0, 3'd5, 3'd2, 3'd1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_valid) begin ok = 1'b1; break; end
      end
      if (!ok) chk("stall_timeout", 0, 1);
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", done_valid, 1);
         chk("stall_result", done_result, 8'h15);
         chk("stall_ready", instr_ready, 0);
         chk("stall_load", rf_load, 0);
      end
      @(posedge clk);
      #1 done_ready = 1'b1;
      wait_done(8'h15, 1'b0);

      // rd == rs1: operands read before the write-back.
      issue(1'b0, 8'h00, 3'd0, 3'd0, 3'd0, 3'd1); wait_done(8'h12, 1'b0);
      chk("lit_r0", env_rf[0], 8'h12);
      issue(1'b1, 8'h00, 3'd0, 3'd6, 3'd0, 3'd0); wait_done(8'h00, 1'b1);
      issue(1'b0, 8'h00, 3'd0, 3'd7, 3'd0, 3'd6); wait_done(8'h12, 1'b0);
      chk("lit_r7", env_rf[7], 8'h12);

      // Reset asserted in the middle of WB: write must be suppressed.
      chk_en = 1'b0;
      instr_imm_en = 1'b0; instr_op = 3'd0; instr_rd = 3'd3;
      instr_rs1 = 3'd0; instr_rs2 = 3'd1; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("wb_load_before_reset", rf_load, 1);
      #1 reset = 1'b0;
      #1;
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      chk("r3_unchanged", env_rf[3], 8'h00);
      reset = 1'b1;
      chk_en = 1'b1;

      issue(1'b1, 8'hA5, 3'd0, 3'd1, 3'd0, 3'd0); wait_done(8'hA5, 1'b0);
      chk("lit_r1", env_rf[1], 8'hA5);
      chk("queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
